line_clear: RTL and testbench

//  - Runs after the falling piece locks. Scans ram_board bottom-up for full rows.
//  - Removes each full row by shifting every row above it down by one, then blanks row 0.
//  - Is a control sub-module selected through module_select, with the same enable/complete

---
 rtl/tetris_pkg.sv | 57 +++++
 rtl/line_clear.sv | 191 +++++++++++++++++++
 tb/tb_line_clear.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/tetris_pkg.sv
// tetris_pkg: shared board geometry, cell-address helper, line_clear state
// encoding and score table for the tetris control sub-modules.
package tetris_pkg;

  localparam int BOARD_W = 10;
  localparam int BOARD_H = 20;
  localparam logic [5:0] EMPTY_COLOUR = 6'd0;

  localparam int ROW_W = 5;
  localparam int COL_W = 4;
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(BOARD_H - 1);
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(BOARD_W - 1);

  // line_clear state encoding
  localparam logic [2:0] LC_ST_IDLE    = 3'd0;
  localparam logic [2:0] LC_ST_SCAN_A  = 3'd1;
  localparam logic [2:0] LC_ST_SCAN_C  = 3'd2;
  localparam logic [2:0] LC_ST_SH_RD   = 3'd3;
  localparam logic [2:0] LC_ST_SH_WR   = 3'd4;
  localparam logic [2:0] LC_ST_CLR_TOP = 3'd5;
  localparam logic [2:0] LC_ST_DONE    = 3'd6;
  localparam logic [2:0] LC_ST_HOLD    = 3'd7;

  typedef enum logic [2:0] {
    S_IDLE    = LC_ST_IDLE,
    S_SCAN_A  = LC_ST_SCAN_A,
    S_SCAN_C  = LC_ST_SCAN_C,
    S_SH_RD   = LC_ST_SH_RD,
    S_SH_WR   = LC_ST_SH_WR,
    S_CLR_TOP = LC_ST_CLR_TOP,
    S_DONE    = LC_ST_DONE,
    S_HOLD    = LC_ST_HOLD
  } lc_state_t;

  // points per run, indexed by rows removed (4 or more share the top entry)
  localparam logic [15:0] SCORE_0 = 16'd0;
  localparam logic [15:0] SCORE_1 = 16'd40;
  localparam logic [15:0] SCORE_2 = 16'd100;
  localparam logic [15:0] SCORE_3 = 16'd300;
  localparam logic [15:0] SCORE_4 = 16'd1200;

  // cell address, computed in 8 bits (board fits in 256 cells)
  function automatic logic [7:0] addr(input logic [ROW_W-1:0] r, input logic [COL_W-1:0] c);
    return 8'(8'(r) * 8'(BOARD_W)) + 8'(c);
  endfunction

  function automatic logic [15:0] score_for(input logic [2:0] n);
    case (n)
      3'd0:    return SCORE_0;
      3'd1:    return SCORE_1;
      3'd2:    return SCORE_2;
      3'd3:    return SCORE_3;
      default: return SCORE_4;
    endcase
  endfunction

endpackage

// File: rtl/line_clear.sv
// line_clear: after a piece locks, scans the board bottom-up and removes every
// full row by moving all rows above it down one, then blanking row 0.
// Owns the ram_board port while enable is high; enable/complete handshake.
//
// Ports:
//   clk, reset_n         clock, async active-low reset
//   enable               held high by control for the whole run
//   ram_q                board read data (one cycle after ram_addr)
//   ram_addr/data/wren   board address, write data, write enable
//   rows_cleared         rows removed this run (saturates at 7)
//   busy                 high while the run is in progress
//   complete             one-cycle pulse at the end of a run
//   score                (only with LINE_CLEAR_SCORE_EN) running score
//
// Build option: define LINE_CLEAR_SCORE_EN to add the score output.
//
// state   | meaning
// IDLE    | waiting for enable
// SCAN_A  | present address of cell (row,col)
// SCAN_C  | test returned cell for EMPTY
// SH_RD   | read cell (dst-1,col)
// SH_WR   | write that cell to (dst,col)
// CLR_TOP | blank row 0, one cell per cycle
// DONE    | complete pulse
// HOLD    | wait for enable to drop
module line_clear
  import tetris_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       enable,
  input  logic [5:0] ram_q,
  output logic [7:0] ram_addr,
  output logic [5:0] ram_data,
  output logic       ram_wren,
  output logic [2:0] rows_cleared,
  output logic       busy,
  output logic       complete
`ifdef LINE_CLEAR_SCORE_EN
  ,
  output logic [15:0] score
`endif
);

  if (BOARD_W * BOARD_H > 256) begin : g_size_check
    $error("line_clear: board does not fit in 8-bit address space");
  end

  lc_state_t        state, state_nxt;
  logic [ROW_W-1:0] row, row_nxt;
  logic [ROW_W-1:0] dst, dst_nxt;
  logic [COL_W-1:0] col, col_nxt;
  logic [2:0]       rc_nxt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= S_IDLE;
      row          <= LAST_ROW;
      col          <= '0;
      dst          <= '0;
      rows_cleared <= '0;
    end else begin
      state        <= state_nxt;
      row          <= row_nxt;
      col          <= col_nxt;
      dst          <= dst_nxt;
      rows_cleared <= rc_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    row_nxt   = row;
    col_nxt   = col;
    dst_nxt   = dst;
    rc_nxt    = rows_cleared;
    ram_addr  = '0;
    ram_data  = EMPTY_COLOUR;
    ram_wren  = 1'b0;
    busy      = 1'b0;
    complete  = 1'b0;

    case (state)
      S_IDLE: begin
        if (enable) begin
          state_nxt = S_SCAN_A;
          row_nxt   = LAST_ROW;
          col_nxt   = '0;
          rc_nxt    = '0;
        end
      end

      S_SCAN_A: begin
        busy      = 1'b1;
        ram_addr  = addr(row, col);
        state_nxt = S_SCAN_C;
      end

      S_SCAN_C: begin
        busy     = 1'b1;
        ram_addr = addr(row, col);
        if (ram_q == EMPTY_COLOUR) begin
          col_nxt = '0;
          if (row == '0) begin
            state_nxt = S_DONE;
          end else begin
            row_nxt   = row - 5'd1;
            state_nxt = S_SCAN_A;
          end
        end else if (col != LAST_COL) begin
          col_nxt   = col + 4'd1;
          state_nxt = S_SCAN_A;
        end else begin
          dst_nxt   = row;
          col_nxt   = '0;
          state_nxt = (row == '0) ? S_CLR_TOP : S_SH_RD;
        end
      end

      S_SH_RD: begin
        busy      = 1'b1;
        ram_addr  = addr(dst - 5'd1, col);
        state_nxt = S_SH_WR;
      end

      S_SH_WR: begin
        busy     = 1'b1;
        ram_addr = addr(dst, col);
        ram_data = ram_q;
        ram_wren = 1'b1;
        if (col != LAST_COL) begin
          col_nxt   = col + 4'd1;
          state_nxt = S_SH_RD;
        end else begin
          col_nxt   = '0;
          dst_nxt   = dst - 5'd1;
          // dst-1 reaching 0 means row 1 was just written: only row 0 is left
          state_nxt = (dst != 5'd1) ? S_SH_RD : S_CLR_TOP;
        end
      end

      S_CLR_TOP: begin
        busy     = 1'b1;
        ram_addr = addr('0, col);
        ram_data = EMPTY_COLOUR;
        ram_wren = 1'b1;
        if (col != LAST_COL) begin
          col_nxt = col + 4'd1;
        end else begin
          col_nxt   = '0;
          rc_nxt    = (rows_cleared == 3'd7) ? 3'd7 : rows_cleared + 3'd1;
          // same row again: it now holds what used to be above it
          state_nxt = S_SCAN_A;
        end
      end

      S_DONE: begin
        complete  = 1'b1;
        state_nxt = S_HOLD;
      end

      S_HOLD: begin
        if (!enable) state_nxt = S_IDLE;
      end

      default: state_nxt = S_IDLE;
    endcase

    // losing enable mid-run abandons the operation; the write strobe is
    // removed in the same cycle so the board is never touched without enable
    if (!enable && (state != S_IDLE) && (state != S_HOLD)) begin
      state_nxt = S_IDLE;
      ram_wren  = 1'b0;
    end
  end

`ifdef LINE_CLEAR_SCORE_EN
  logic [16:0] score_sum;
  assign score_sum = {1'b0, score} + {1'b0, score_for(rows_cleared)};

  // not cleared on IDLE exit: accumulates across runs until reset
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      score <= '0;
    end else if (state == S_DONE) begin
      score <= score_sum[16] ? 16'hFFFF : score_sum[15:0];
    end
  end
`endif

endmodule

// File: tb/tb_line_clear.sv
module tb_line_clear;
  import tetris_pkg::*;

  localparam int NCELL = BOARD_W * BOARD_H;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       enable = 1'b0;
  logic [5:0] ram_q;
  logic [7:0] ram_addr;
  logic [5:0] ram_data;
  logic       ram_wren;
  logic [2:0] rows_cleared;
  logic       busy;
  logic       complete;
`ifdef LINE_CLEAR_SCORE_EN
  logic [15:0] score;
`endif

  int errors = 0;
  int checks = 0;

  logic [5:0] mem    [0:255];
  logic [5:0] init_b [0:255];
  logic [5:0] exp_b  [0:255];
  logic [5:0] wb     [0:255];
  logic       load = 1'b0;
  int         exp_rows;
  int         exp_lat;
  int         exp_score = 0;

  line_clear dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .enable       (enable),
    .ram_q        (ram_q),
    .ram_addr     (ram_addr),
    .ram_data     (ram_data),
    .ram_wren     (ram_wren),
    .rows_cleared (rows_cleared),
    .busy         (busy),
    .complete     (complete)
`ifdef LINE_CLEAR_SCORE_EN
    ,
    .score        (score)
`endif
  );

  always #5 clk = ~clk;

  // board RAM: synchronous read, write-enable port
  always @(posedge clk) begin
    if (load) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_b[i];
    end else if (ram_wren) begin
      mem[ram_addr] <= ram_data;
    end
    ram_q <= mem[ram_addr];
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic clear_init();
    for (int i = 0; i < 256; i++) init_b[i] = 6'd0;
  endtask

  task automatic set_row(input int r, input logic [5:0] c);
    for (int k = 0; k < BOARD_W; k++) init_b[r*BOARD_W+k] = c;
  endtask

  task automatic load_board();
    @(negedge clk);
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  function automatic int pts(input int n);
    case (n)
      0: return 0;
      1: return 40;
      2: return 100;
      3: return 300;
      default: return 1200;
    endcase
  endfunction

  // Expected board by compaction (keep non-full rows in order, packed to the
  // bottom); expected latency from per-row scan/shift/clear costs.
  task automatic build_model();
    int  dstr, n, k, cyc;
    int  r;
    bit  full;
    for (int i = 0; i < 256; i++) exp_b[i] = 6'd0;
    dstr = BOARD_H - 1;
    n = 0;
    for (r = BOARD_H - 1; r >= 0; r--) begin
      full = 1'b1;
      for (int c = 0; c < BOARD_W; c++) if (init_b[r*BOARD_W+c] == 6'd0) full = 1'b0;
      if (full) n++;
      else begin
        for (int c = 0; c < BOARD_W; c++) exp_b[dstr*BOARD_W+c] = init_b[r*BOARD_W+c];
        dstr--;
      end
    end
    exp_rows = (n > 7) ? 7 : n;

    for (int i = 0; i < 256; i++) wb[i] = init_b[i];
    r = BOARD_H - 1;
    cyc = 0;
    for (int guard = 0; guard < 1000; guard++) begin
      k = BOARD_W;
      for (int c = BOARD_W - 1; c >= 0; c--) if (wb[r*BOARD_W+c] == 6'd0) k = c;
      if (k < BOARD_W) begin
        cyc += 2 * (k + 1);
        if (r == 0) break;
        r--;
      end else begin
        cyc += 3 * BOARD_W + 2 * BOARD_W * r;
        for (int rr = r; rr > 0; rr--)
          for (int c = 0; c < BOARD_W; c++) wb[rr*BOARD_W+c] = wb[(rr-1)*BOARD_W+c];
        for (int c = 0; c < BOARD_W; c++) wb[c] = 6'd0;
      end
    end
    exp_lat = cyc + 1;
  endtask

  task automatic check_board(input string tag);
    int bad;
    bad = -1;
    for (int i = 0; i < NCELL; i++)
      if (mem[i] !== exp_b[i] && bad < 0) bad = i;
    checks++;
    if (bad >= 0) begin
      errors++;
      $display("FAIL %s board: cell %0d got %0d expected %0d", tag, bad, mem[bad], exp_b[bad]);
    end
  endtask

  task automatic run_case(input string tag, input int lit_lat);
    int seen;
    int exp_bc;
    build_model();
    load_board();
    seen = -1;
    @(negedge clk);
    enable = 1'b1;
    for (int k = 1; k <= exp_lat + 1; k++) begin
      @(posedge clk);
      #1;
      exp_bc = (k < exp_lat) ? 2 : ((k == exp_lat) ? 1 : 0);
      chk({tag, " busy/complete"}, {30'd0, busy, complete}, exp_bc);
      if (complete && seen < 0) seen = k;
      if (k == exp_lat) chk({tag, " rows_cleared"}, rows_cleared, exp_rows);
    end
`ifdef LINE_CLEAR_SCORE_EN
    exp_score = exp_score + pts(exp_rows);
    if (exp_score > 65535) exp_score = 65535;
    chk({tag, " score"}, score, exp_score);
`endif
    check_board(tag);
    if (lit_lat >= 0) chk({tag, " latency"}, seen, lit_lat);
    @(negedge clk);
    enable = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_wren(input string tag);
    for (int k = 0; k < 2000 && !ram_wren; k++) begin
      @(posedge clk);
      #1;
    end
    chk({tag, " reached write"}, ram_wren, 1);
  endtask

  initial begin
    // reset state, sampled before any clock edge
    #3;
    chk("reset busy", busy, 0);
    chk("reset complete", complete, 0);
    chk("reset wren", ram_wren, 0);
    chk("reset addr", ram_addr, 0);
    chk("reset rows_cleared", rows_cleared, 0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // 1: empty board
    clear_init();
    run_case("t1_empty", 41);

    // 2: row 19 full, one block above it
    clear_init();
    set_row(19, 6'd3);
    init_b[18*BOARD_W+4] = 6'd5;
    run_case("t2_one_row", 451);
    chk("t2 cell 194", mem[194], 5);
    chk("t2 cell 184", mem[184], 0);

    // 3: four full rows, one block above
    clear_init();
    for (int r = 16; r < 20; r++) set_row(r, 6'd1);
    init_b[15*BOARD_W] = 6'd7;
    run_case("t3_tetris", -1);
    chk("t3 cell 190", mem[190], 7);
    chk("t3 rows_cleared held", rows_cleared, 4);

    // 4: rows 19 and 17 full, row 18 half full
    clear_init();
    set_row(19, 6'd4);
    set_row(17, 6'd4);
    for (int c = 0; c < 5; c++) init_b[18*BOARD_W+c] = 6'd2;
    run_case("t4_split", -1);
    chk("t4 cell 192", mem[192], 2);
    chk("t4 cell 195", mem[195], 0);

    // 5: drop enable during a shift write
    clear_init();
    set_row(19, 6'd3);
    load_board();
    @(negedge clk);
    enable = 1'b1;
    wait_wren("t5");
    #2;
    enable = 1'b0;
    #1;
    chk("t5 wren drops", ram_wren, 0);
    @(posedge clk);
    #1;
    chk("t5 idle busy", busy, 0);
    chk("t5 idle addr", ram_addr, 0);
    for (int k = 0; k < 5; k++) begin
      chk("t5 no complete", complete, 0);
      @(posedge clk);
      #1;
    end

    // 6: async reset during the second row's shift
    clear_init();
    for (int r = 16; r < 20; r++) set_row(r, 6'd1);
    load_board();
    @(negedge clk);
    enable = 1'b1;
    for (int k = 0; k < 2000 && rows_cleared == 3'd0; k++) begin
      @(posedge clk);
      #1;
    end
    chk("t6 first row cleared", rows_cleared, 1);
    wait_wren("t6");
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    chk("t6 reset busy", busy, 0);
    chk("t6 reset wren", ram_wren, 0);
    chk("t6 reset addr", ram_addr, 0);
    chk("t6 reset data", ram_data, 0);
    chk("t6 reset rows_cleared", rows_cleared, 0);
    chk("t6 reset complete", complete, 0);
`ifdef LINE_CLEAR_SCORE_EN
    chk("t6 reset score", score, 0);
    exp_score = 0;
`endif
    enable = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    clear_init();
    run_case("t6_rerun", 41);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
